// File: rtl/bcd_countdown.sv
// Multi-decade packed-BCD down-counter/timer with validated parallel load,
// decade borrow, one-cycle expiry pulse and optional auto-reload.
module bcd_countdown #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  running,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [W-1:0]   q_dec;

    function automatic logic bcd_valid(input logic [W-1:0] v);
        bcd_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) bcd_valid = 1'b0;
        end
    endfunction

    // Ripple borrow: a digit decrements only while every lower digit was 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic       borrow;
        logic [3:0] d;
        bcd_dec = v;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    bcd_dec[4*k +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*k +: 4] = d - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    endfunction

    assign q_dec = bcd_dec(q_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (load) begin
            if (bcd_valid(load_val)) begin
                q_d      = load_val;
                reload_d = load_val;
                state_d  = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start && state_q == IDLE) begin
            if (q_q != '0) state_d = RUN;
        end else if (state_q == RUN && en) begin
            // Zero while still in RUN only happens after an auto-reload expiry.
            if (q_q == '0) begin
                if (reload_q != '0) q_d = reload_q;
                else                state_d = EXPIRED;
            end else begin
                q_d = q_dec;
                if (q_dec == '0) begin
                    done_d = 1'b1;
                    if (!AUTO_RELOAD || reload_q == '0) state_d = EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them see pre-edge values.
        if (!rstn) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Q        = q_q;
    assign running  = (state_q == RUN);
    assign done     = done_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: one stop-at-zero instance and one
// auto-reload instance, checked through an expected-value queue.
module tb_bcd_countdown;

    logic        clk = 1'b0;
    logic        rstn;

    logic        a_load, a_start, a_stop, a_en;
    logic [15:0] a_load_val, a_q;
    logic        a_running, a_done, a_err;

    logic        b_load, b_start, b_stop, b_en;
    logic [15:0] b_load_val, b_q;
    logic        b_running, b_done, b_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [15:0] q;
        logic        run;
        logic        dn;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_countdown #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rstn(rstn), .load(a_load), .load_val(a_load_val),
        .start(a_start), .stop(a_stop), .en(a_en),
        .Q(a_q), .running(a_running), .done(a_done), .load_err(a_err)
    );

    bcd_countdown #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rstn(rstn), .load(b_load), .load_val(b_load_val),
        .start(b_start), .stop(b_stop), .en(b_en),
        .Q(b_q), .running(b_running), .done(b_done), .load_err(b_err)
    );

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [18:0] obs, want;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            obs  = e.sel ? {b_q, b_running, b_done, b_err} : {a_q, a_running, a_done, a_err};
            want = {e.q, e.run, e.dn, e.err};
            n_cmp++;
            assert (obs === want) else begin
                n_bad++;
                $error("FAIL %s: Q/run/done/err got %h/%b/%b/%b want %h/%b/%b/%b", e.tag,
                       obs[18:3], obs[2], obs[1], obs[0], e.q, e.run, e.dn, e.err);
            end
        end
    endtask

    // Drive one cycle of inputs to the selected instance, queue its expected
    // outputs after the edge, then compare.
    task automatic step(input bit sel, input bit ld, input logic [15:0] lv,
                        input bit st, input bit sp, input bit e, input string tag,
                        input logic [15:0] eq, input bit er, input bit ed, input bit ee);
        exp_t x;
        a_load = 1'b0; a_load_val = '0; a_start = 1'b0; a_stop = 1'b0; a_en = 1'b0;
        b_load = 1'b0; b_load_val = '0; b_start = 1'b0; b_stop = 1'b0; b_en = 1'b0;
        if (sel) begin
            b_load = ld; b_load_val = lv; b_start = st; b_stop = sp; b_en = e;
        end else begin
            a_load = ld; a_load_val = lv; a_start = st; a_stop = sp; a_en = e;
        end
        x.tag = tag; x.sel = sel; x.q = eq; x.run = er; x.dn = ed; x.err = ee;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        int          cnt;
        logic [15:0] ar_q;
        bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset dominates a simultaneous load.
        rstn = 1'b0;
        step(0, 1, 16'h1234, 0, 0, 0, "reset0", 16'h0000, 0, 0, 0);
        step(0, 1, 16'h5678, 1, 0, 1, "reset1", 16'h0000, 0, 0, 0);
        step(1, 1, 16'h0009, 1, 0, 1, "reset_ar", 16'h0000, 0, 0, 0);
        rstn = 1'b1;

        // Count 100 down to 0 with decade borrow, then hold in EXPIRED.
        step(0, 1, 16'h0100, 0, 0, 0, "load100", 16'h0100, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, "start100", 16'h0100, 1, 0, 0);
        for (int i = 1; i <= 100; i++)
            step(0, 0, 16'h0000, 0, 0, 1, "count100", to_bcd(100 - i), i < 100, i == 100, 0);
        for (int i = 0; i < 20; i++)
            step(0, 0, 16'h0000, 0, 0, 1, "hold_zero", 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 1, "start_expired", 16'h0000, 0, 0, 0);

        // Invalid load is rejected; a valid load beats a simultaneous start.
        step(0, 1, 16'h0042, 0, 0, 0, "load42", 16'h0042, 0, 0, 0);
        step(0, 1, 16'h00A3, 0, 0, 0, "bad_load", 16'h0042, 0, 0, 1);
        step(0, 0, 16'h0000, 0, 0, 0, "err_clear", 16'h0042, 0, 0, 0);
        step(0, 1, 16'hF000, 0, 0, 0, "bad_hi", 16'h0042, 0, 0, 1);
        step(0, 1, 16'h0007, 1, 0, 1, "load_start", 16'h0007, 0, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 1, "idle_en", 16'h0007, 0, 0, 0);

        // Stop holds Q, restart finishes the count.
        step(0, 1, 16'h0020, 0, 0, 0, "load20", 16'h0020, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, "start20", 16'h0020, 1, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 16'h0000, 0, 0, 1, "count20", to_bcd(20 - i), 1, 0, 0);
        step(0, 0, 16'h0000, 0, 1, 1, "stop", 16'h0015, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, "restart", 16'h0015, 1, 0, 0);
        for (int i = 1; i <= 15; i++)
            step(0, 0, 16'h0000, 0, 0, 1, "count15", to_bcd(15 - i), i < 15, i == 15, 0);

        // A load during RUN returns to IDLE with the new value.
        step(0, 1, 16'h0011, 0, 0, 0, "load11", 16'h0011, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, "start11", 16'h0011, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 1, "tick10", 16'h0010, 1, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 1, "borrow09", 16'h0009, 1, 0, 0);
        step(0, 1, 16'h0050, 0, 0, 1, "load_in_run", 16'h0050, 0, 0, 0);

        // Gated enable, then start attempts at zero.
        step(0, 1, 16'h0003, 0, 0, 0, "load3", 16'h0003, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 0, "start3", 16'h0003, 1, 0, 0);
        cnt = 3;
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) cnt--;
            step(0, 0, 16'h0000, 0, 0, pat[i], "gated_en", to_bcd(cnt), i < 5, i == 5, 0);
        end
        step(0, 0, 16'h0000, 1, 0, 1, "start_at_zero", 16'h0000, 0, 0, 0);
        step(0, 1, 16'h0000, 0, 0, 0, "load0", 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0000, 1, 0, 1, "start_idle0", 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0000, 0, 0, 1, "stay_idle0", 16'h0000, 0, 0, 0);

        // Auto-reload: period of reload+1 ticks, done at every zero.
        step(1, 1, 16'h0002, 0, 0, 0, "ar_load2", 16'h0002, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 1, "ar_start", 16'h0002, 1, 0, 0);
        ar_q = 16'h0002;
        for (int i = 0; i < 9; i++) begin
            ar_q = (ar_q == 16'h0000) ? 16'h0002 : ar_q - 16'h0001;
            step(1, 0, 16'h0000, 0, 0, 1, "ar_cycle", ar_q, 1, ar_q == 16'h0000, 0);
        end
        step(1, 1, 16'h0000, 0, 0, 1, "ar_load0", 16'h0000, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 1, "ar_start0", 16'h0000, 0, 0, 0);

        // Reset on the edge that would have expired: no done pulse.
        step(1, 1, 16'h0002, 0, 0, 0, "ar_reload2", 16'h0002, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0, "ar_restart", 16'h0002, 1, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 1, "ar_tick1", 16'h0001, 1, 0, 0);
        rstn = 1'b0;
        step(1, 0, 16'h0000, 0, 0, 1, "ar_reset_mid", 16'h0000, 0, 0, 0);
        rstn = 1'b1;
        step(1, 0, 16'h0000, 0, 0, 1, "ar_after_reset", 16'h0000, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 1, "ar_start_after", 16'h0000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
